instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the opcode controller: holds the PC, fetches one instruction per
//  execution slot over a req/ack instruction-memory handshake, and presents inst/opc to decode.
//  Consumes the controller's jPC/branch outputs plus ALU zero to select the next PC.
//  Sole owner of the architectural PC; provides pc_plus4 for link writes.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  CNT_W       32             width of retired-instruction counter (IFU_PERF_CNT_EN only)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-high
//  imem_req     out  1   fetch request; high only in FETCH
//  imem_addr    out  32  fetch address (= pc)
//  imem_ack     in   1   memory returns imem_rdata this cycle; valid only while imem_req=1
//  imem_rdata   in   32  instruction word, sampled when imem_req & imem_ack
//  inst         out  32  held instruction word
//  opc          out  6   inst[31:26], to opcode controller
//  inst_valid   out  1   inst/opc valid, core may execute
//  exec_done    in   1   core finished held instruction; jPC/branch/zero/rs_data valid this cycle
//  jPC          in   2   00 PC+4, 01 jump target, 10 register target, 11 treated as 00
//  branch       in   2   01 beq, 10 bne, 00/11 no branch
//  zero         in   1   ALU zero flag
//  rs_data      in   32  register-target source
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (mod 2^32), link value
//  retired_cnt  out  CNT_W  instructions retired (IFU_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, inst=0, inst_valid=0, imem_req=0 in the reset cycle,
//    retired_cnt=0. Outstanding fetch abandoned; an ack during reset is ignored.
//  - FSM, two states:
//    FETCH: imem_req=1, imem_addr=pc, inst_valid=0. On imem_ack: inst<=imem_rdata, ->HOLD.
//           No ack: stay, address stable (no timeout).
//    HOLD:  imem_req=0, inst_valid=1, inst stable. On exec_done: pc<=next_pc, ->FETCH.
//  - Latency: req in the first cycle after rst falls; ack in same cycle as req is legal ->
//    inst_valid next cycle. Minimum 2 cycles/instruction (FETCH+HOLD) with zero-wait memory.
//  - next_pc (combinational, priority order):
//    jPC=01 -> {pc_plus4[31:28], inst[25:0], 2'b00}
//    jPC=10 -> {rs_data[31:2], 2'b00} (low bits forced 0)
//    else branch=01 & zero, or branch=10 & !zero -> pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}
//    else -> pc_plus4
//  - Jump overrides branch when both asserted. All adds wrap modulo 2^32 (0xFFFF_FFFC+4 = 0).
//  - imem_ack outside FETCH and exec_done outside HOLD: ignored, no state change.
//  - pc changes only on HOLD & exec_done or reset; pc_plus4 always pc+4.
//  - opc is a wire from inst: 0 whenever inst=0 (after reset).
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: retired_cnt increments by 1 on each HOLD & exec_done, wraps at 2^CNT_W,
//    cleared by rst.
//  Undefined: retired_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  - Reset, RESET_PC=0, zero-wait mem returning 0x2008_0005 -> imem_addr=0 cycle 1,
//    inst_valid cycle 2, opc=6'b001000.
//  - Sequential: exec_done, jPC=00, branch=00 at pc=0x10 -> next fetch addr 0x14, pc_plus4=0x18.
//  - beq taken: inst[15:0]=0xFFFF, branch=01, zero=1, pc=0x20 -> next pc 0x20;
//    zero=0 -> next pc 0x24.
//  - Jump: pc=0x4000_0000, inst[25:0]=0x000_0010, jPC=01, branch=01, zero=1 -> next pc
//    0x4000_0040 (jump wins).
//  - Register target: jPC=10, rs_data=0x0000_1237 -> next pc 0x1234.
//  - Wait states / reset mid-fetch: ack held low 5 cycles -> imem_addr stable, inst_valid=0;
//    rst in cycle 3 -> pc=RESET_PC, late ack ignored; with IFU_PERF_CNT_EN, 3 retires -> retired_cnt=3.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the opcode controller. Owns the architectural PC,
//   fetches one instruction word per execution slot over a req/ack memory
//   handshake, holds it for decode/execute, and selects the next PC from the
//   controller's jPC/branch outputs and the ALU zero flag.
//
//   Two-state FSM: FETCH (request outstanding) and HOLD (instruction valid,
//   waiting for the core to finish it). Zero-wait memory gives one
//   instruction every two cycles.
//
//   Optional feature macro: IFU_PERF_CNT_EN
//     defined   -> retired_cnt port plus a CNT_W-bit retired-instruction
//                  counter (increments on every HOLD & exec_done, wraps).
//     undefined -> no retired_cnt port, no counter logic.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    // instruction memory handshake
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    // decode side
    output logic [31:0]      inst,
    output logic [5:0]       opc,
    output logic             inst_valid,
    // execute feedback
    input  logic             exec_done,
    input  logic [1:0]       jPC,
    input  logic [1:0]       branch,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    // architectural PC
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // jPC selector codes; 2'b11 deliberately falls through to sequential
    localparam logic [1:0] JPC_JUMP = 2'b01;
    localparam logic [1:0] JPC_REG  = 2'b10;

    // branch selector codes; 2'b00 / 2'b11 mean no branch
    localparam logic [1:0] BR_BEQ   = 2'b01;
    localparam logic [1:0] BR_BNE   = 2'b10;

    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] inst_reg;
    logic [31:0] inst_next;

    logic [31:0] pc_plus4_w;
    logic [31:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [31:0] target_pc;
    logic        in_fetch;
    logic        in_hold;
    logic        retire;

    // rs_data low bits are discarded because register targets are word aligned
    logic        unused_rs_low;
    assign unused_rs_low = ^rs_data[1:0];

    assign in_fetch = (state_reg == ST_FETCH);
    assign in_hold  = (state_reg == ST_HOLD);
    assign retire   = in_hold && exec_done;

    // Sequential PC and link value; wraps naturally at 2^32
    assign pc_plus4_w = pc_reg + 32'd4;

    // Absolute jump keeps the region bits of the following instruction
    assign jump_target = {pc_plus4_w[31:28], inst_reg[25:0], 2'b00};

    // Register target is forced to a word boundary
    assign reg_target = {rs_data[31:2], 2'b00};

    // Branch offset: imm16 shifted left by two, sign bit replicated upwards
    assign branch_offset[1:0]  = 2'b00;
    assign branch_offset[17:2] = inst_reg[15:0];
    generate
        for (genvar gi = 18; gi < 32; gi++) begin : g_br_sext
            assign branch_offset[gi] = inst_reg[15];
        end
    endgenerate

    assign branch_target = pc_plus4_w + branch_offset;

    // Branch condition: beq taken on zero, bne taken on non-zero
    always_comb begin
        branch_taken = 1'b0;
        if (branch == BR_BEQ) begin
            branch_taken = zero;
        end else if (branch == BR_BNE) begin
            branch_taken = !zero;
        end
    end

    // Next-PC select: any jump outranks a branch, branch outranks sequential
    always_comb begin
        target_pc = pc_plus4_w;
        if (jPC == JPC_JUMP) begin
            target_pc = jump_target;
        end else if (jPC == JPC_REG) begin
            target_pc = reg_target;
        end else if (branch_taken) begin
            target_pc = branch_target;
        end
    end

    // FSM transitions; handshake inputs outside their own state are ignored
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        if (in_fetch) begin
            if (imem_ack) begin
                inst_next  = imem_rdata;
                state_next = ST_HOLD;
            end
        end else begin
            if (exec_done) begin
                pc_next    = target_pc;
                state_next = ST_FETCH;
            end
        end
    end

    // State, PC and held instruction; reset abandons any outstanding fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
        end
    end

    // Request and valid are masked during reset so nothing leaks out while
    // the state register is still being forced back to FETCH
    assign imem_req   = in_fetch && !rst;
    assign inst_valid = in_hold && !rst;
    assign imem_addr  = pc_reg;
    assign inst       = inst_reg;
    assign opc        = inst_reg[31:26];
    assign pc         = pc_reg;
    assign pc_plus4   = pc_plus4_w;

`ifdef IFU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Counter advances once per retired instruction and wraps silently
    always_comb begin
        cnt_next = cnt_reg;
        if (retire) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign retired_cnt = cnt_reg;
`else
    // Counter width only matters when the counter is built
    localparam int UNUSED_CNT_W = CNT_W;
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Randomised bench for instr_fetch_unit. A behavioural model (current PC,
//   whether an instruction is held, the held word, retire count) follows the
//   documented fetch/execute rules; next PC is computed with plain integer
//   arithmetic. Inputs are driven on the falling edge, outputs checked 1 ns
//   later, and the model advances on the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 32;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [5:0]  opc;
    logic        inst_valid;
    logic        exec_done;
    logic [1:0]  jPC;
    logic [1:0]  branch;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IFU_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .opc        (opc),
        .inst_valid (inst_valid),
        .exec_done  (exec_done),
        .jPC        (jPC),
        .branch     (branch),
        .zero       (zero),
        .rs_data    (rs_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
`ifdef IFU_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_inst;
    int unsigned m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Next PC straight from the instruction-set rules
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic [1:0] j, input logic [1:0] b,
                                               input logic z, input logic [31:0] rs);
        logic [31:0] seq;
        int          imm;
        seq = cur + 32'd4;
        if (j == 2'd1) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        if (j == 2'd2) return rs & 32'hFFFF_FFFC;
        if ((b == 2'd1 && z) || (b == 2'd2 && !z)) begin
            imm = int'(word[15:0]);
            if (imm >= 32768) imm = imm - 65536;
            return seq + 32'(imm * 4);
        end
        return seq;
    endfunction

    // Output checks that hold in every cycle
    task automatic check_outputs();
        check_eq("imem_req", 32'(imem_req), 32'(!m_hold));
        check_eq("inst_valid", 32'(inst_valid), 32'(m_hold));
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("inst", inst, m_inst);
        check_eq("opc", 32'(opc), 32'(m_inst >> 26));
`ifdef IFU_PERF_CNT_EN
        check_eq("retired_cnt", 32'(retired_cnt), m_cnt);
`endif
    endtask

    // One clock cycle with rst low
    task automatic step(input logic a, input logic [31:0] d, input logic dn,
                        input logic [1:0] j, input logic [1:0] b, input logic z,
                        input logic [31:0] rs);
        logic [31:0] nxt;
        @(negedge clk);
        rst = 1'b0; imem_ack = a; imem_rdata = d; exec_done = dn;
        jPC = j; branch = b; zero = z; rs_data = rs;
        #1;
        check_outputs();
        @(posedge clk);
        if (!m_hold && a) begin
            m_inst = d;
            m_hold = 1'b1;
        end else if (m_hold && dn) begin
            nxt = model_next(m_pc, m_inst, j, b, z, rs);
            $display("[TB] retire pc=%h inst=%h jPC=%0d br=%0d z=%0d -> next=%h",
                     m_pc, m_inst, j, b, z, nxt);
            m_pc   = nxt;
            m_hold = 1'b0;
            m_cnt++;
        end
    endtask

    // One reset cycle with a competing ack, which must be ignored
    task automatic reset_step();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom; exec_done = 1'b1;
        jPC = 2'($urandom); branch = 2'($urandom); zero = 1'($urandom); rs_data = $urandom;
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        @(posedge clk);
        m_pc = RESET_PC; m_hold = 1'b0; m_inst = 32'd0; m_cnt = 0;
        $display("[TB] reset pc=%h", m_pc);
    endtask

    // Fetch a word after 'waits' cycles without ack; stray exec_done is noise
    task automatic fetch(input logic [31:0] w, input int waits);
        repeat (waits) step(1'b0, $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
                            1'($urandom), $urandom);
        step(1'b1, w, 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom);
    endtask

    // Execute the held word after 'waits' cycles; stray acks are noise
    task automatic exec(input logic [1:0] j, input logic [1:0] b, input logic z,
                        input logic [31:0] rs, input int waits);
        repeat (waits) step(1'($urandom), $urandom, 1'b0, 2'($urandom), 2'($urandom),
                            1'($urandom), $urandom);
        step(1'($urandom), $urandom, 1'b1, j, b, z, rs);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        jPC = '0; branch = '0; zero = 1'b0; rs_data = '0;
        m_pc = RESET_PC; m_hold = 1'b0; m_inst = '0; m_cnt = 0;
        repeat (2) @(posedge clk);

        // reset then zero-wait fetch of an addi-style word
        reset_step();
        #1;
        check_eq("reset_inst", inst, 32'd0);
        check_eq("reset_opc", 32'(opc), 32'd0);
        fetch(32'h2008_0005, 0);
        #1;
        check_eq("first_valid", 32'(inst_valid), 32'd1);
        check_eq("first_opc", 32'(opc), 32'h08);

        // sequential step from 0x10
        exec(2'd2, 2'd0, 1'b0, 32'h0000_0010, 0);
        fetch($urandom, 1);
        exec(2'd0, 2'd0, 1'b0, $urandom, 1);
        #1;
        check_eq("seq_pc", pc, 32'h14);
        check_eq("seq_pc_plus4", pc_plus4, 32'h18);

        // beq with offset -1 at 0x20: taken loops back, not taken falls through
        fetch($urandom, 0);
        exec(2'd2, 2'd0, 1'b0, 32'h0000_0020, 0);
        fetch(32'h1000_FFFF, 0);
        exec(2'd0, 2'd1, 1'b1, $urandom, 0);
        #1;
        check_eq("beq_taken_pc", pc, 32'h20);
        fetch(32'h1000_FFFF, 2);
        exec(2'd0, 2'd1, 1'b0, $urandom, 2);
        #1;
        check_eq("beq_not_taken_pc", pc, 32'h24);

        // jump beats a taken branch
        fetch($urandom, 0);
        exec(2'd2, 2'd0, 1'b0, 32'h4000_0000, 0);
        fetch(32'h0800_0010, 0);
        exec(2'd1, 2'd1, 1'b1, $urandom, 0);
        #1;
        check_eq("jump_pc", pc, 32'h4000_0040);

        // register target, low bits dropped
        fetch($urandom, 0);
        exec(2'd2, 2'd0, 1'b0, 32'h0000_1237, 0);
        #1;
        check_eq("reg_target_pc", pc, 32'h1234);

        // wrap at the top of the address space
        fetch($urandom, 0);
        exec(2'd2, 2'd0, 1'b0, 32'hFFFF_FFFF, 0);
        #1;
        check_eq("top_pc", pc, 32'hFFFF_FFFC);
        check_eq("top_pc_plus4", pc_plus4, 32'h0);
        fetch($urandom, 0);
        exec(2'd3, 2'd0, 1'b0, $urandom, 0);
        #1;
        check_eq("wrap_pc", pc, 32'h0);

        // long wait states then reset in the middle of a fetch
        fetch($urandom, 0);
        exec(2'd2, 2'd0, 1'b0, 32'h0000_1234, 0);
        repeat (5) step(1'b0, $urandom, 1'b1, 2'd1, 2'd1, 1'b1, $urandom);
        reset_step();
        #1;
        check_eq("midfetch_pc", pc, RESET_PC);
        check_eq("midfetch_valid", 32'(inst_valid), 32'd0);
        step(1'b0, $urandom, 1'b1, 2'd0, 2'd0, 1'b0, $urandom);
        #1;
        check_eq("late_ack_ignored", 32'(inst_valid), 32'd0);

        // three retires from reset
        for (int k = 0; k < 3; k++) begin
            fetch($urandom, k);
            exec(2'd0, 2'd0, 1'b0, $urandom, k);
        end
`ifdef IFU_PERF_CNT_EN
        #1;
        check_eq("three_retires", 32'(retired_cnt), 32'd3);
`endif
        #1;
        check_eq("three_retires_pc", pc, RESET_PC + 32'd12);

        // random traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) reset_step();
            fetch($urandom, int'($urandom_range(0, 3)));
            exec(2'($urandom), 2'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
